// File: rtl/rom_loader.sv
// -----------------------------------------------------------------------------
// rom_loader
//   Download sequencer between the HPS ioctl byte stream and the MCR3 ROM
//   stores. Each accepted byte of download index 0 becomes either a toggle
//   request on SDRAM port 1 (CPU ROMs), a toggle request on SDRAM port 2
//   (sprite ROMs, with address scrambling), or a one-cycle write strobe into
//   the background ROM BRAM. Addresses beyond the background region are
//   dropped. One byte arriving while a request is outstanding is held in a
//   single-entry skid buffer; the HPS is held off with ioctl_wait.
//
// Ports
//   clk_sys, reset_n                 clock, async active-low reset
//   ioctl_download/wr/index/addr/dout HPS download stream
//   ioctl_wait                       HPS hold-off
//   port1_req/ack/a/ds/d             SDRAM port 1 toggle handshake + payload
//   port2_req/ack/a/ds/d             SDRAM port 2 toggle handshake + payload
//   rom_we                           high while a ROM download (index 0) runs
//   dl_wr/dl_addr/dl_data            background ROM BRAM write
//   load_done                        one-cycle pulse when the download ends
//   load_err                         sticky ack-timeout / lost-byte flag
// -----------------------------------------------------------------------------
module rom_loader #(
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_index,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic [22:0] port1_a,
  output logic [1:0]  port1_ds,
  output logic [15:0] port1_d,
  output logic        port2_req,
  input  logic        port2_ack,
  output logic [17:0] port2_a,
  output logic [1:0]  port2_ds,
  output logic [15:0] port2_d,
  output logic        rom_we,
  output logic        dl_wr,
  output logic [14:0] dl_addr,
  output logic [7:0]  dl_data,
  output logic        load_done,
  output logic        load_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int            CW       = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // registered state
  state_t        state_r;
  logic          dl_q_r;       // ioctl_download delayed, for edge detect
  logic          tgt2_r;       // outstanding request is on port 2
  logic          pol1_r;       // ack polarity correction after a timeout
  logic          pol2_r;
  logic [CW-1:0] cnt_r;
  logic          skid_v_r;
  logic [24:0]   skid_addr_r;
  logic [7:0]    skid_data_r;
  logic          pend_r;       // download ended while a request was outstanding
  logic          err_r;
  logic          done_r;
  logic          wait_r;
  logic          req1_r;
  logic [22:0]   a1_r;
  logic [1:0]    ds1_r;
  logic [15:0]   d1_r;
  logic          req2_r;
  logic [17:0]   a2_r;
  logic [1:0]    ds2_r;
  logic [15:0]   d2_r;
  logic          dlwr_r;
  logic [14:0]   dladdr_r;
  logic [7:0]    dldata_r;

  // combinational helpers
  logic        acc_s, fall_s, rise_s, match_s, tmo_s, exit_s, tmo_err_s;
  logic        use_skid_s;
  logic [24:0] sel_addr_s;
  logic [7:0]  sel_data_s;
  logic        r1_s, r2_s, bg_s;
  logic [18:0] s_off_s;
  logic [14:0] b_off_s;
  logic        issue_s, sdram_s, skid_v_n_s, skid_cap_s, lost_s, pend_n_s;
  state_t      state_n_s;

  assign acc_s  = ioctl_wr & ioctl_download & (ioctl_index == 8'd0);
  assign fall_s = dl_q_r & ~ioctl_download;
  assign rise_s = ~dl_q_r & ioctl_download;
  assign rom_we = ioctl_download & (ioctl_index == 8'd0);

  // Ack matches when the polarity-corrected ack of the target port equals its req.
  assign match_s = tgt2_r ? ((port2_ack ^ pol2_r) == req2_r)
                          : ((port1_ack ^ pol1_r) == req1_r);
  assign tmo_s      = (cnt_r == TMO_LAST);
  assign exit_s     = (state_r == ST_WAIT) & (match_s | tmo_s);
  assign tmo_err_s  = exit_s & ~match_s;
  assign use_skid_s = exit_s & skid_v_r;

  // Select the byte to issue (skid entry has priority at WAIT exit) and decode its region.
  always_comb begin
    sel_addr_s = ioctl_addr;
    sel_data_s = ioctl_dout;
    if (use_skid_s) begin
      sel_addr_s = skid_addr_r;
      sel_data_s = skid_data_r;
    end else begin
      sel_addr_s = ioctl_addr;
      sel_data_s = ioctl_dout;
    end
    r1_s    = (sel_addr_s < 25'h0012000);
    r2_s    = ~r1_s & (sel_addr_s < 25'h0032000);
    bg_s    = ~r1_s & ~r2_s & (sel_addr_s < 25'h003A000);
    // Only the low bits of the offsets matter, so subtract modulo their width.
    s_off_s = sel_addr_s[18:0] - 19'h12000;
    b_off_s = sel_addr_s[14:0] - 15'h2000;
  end

  // Decide whether a byte issues this cycle and manage the skid buffer.
  always_comb begin
    issue_s    = 1'b0;
    skid_v_n_s = skid_v_r;
    skid_cap_s = 1'b0;
    lost_s     = 1'b0;
    case (state_r)
      ST_WAIT: begin
        if (exit_s) begin
          if (skid_v_r) begin
            issue_s    = 1'b1;
            skid_v_n_s = acc_s;
            skid_cap_s = acc_s;
          end else begin
            issue_s    = acc_s;
            skid_v_n_s = 1'b0;
          end
        end else if (acc_s) begin
          if (skid_v_r) begin
            lost_s = 1'b1;
          end else begin
            skid_v_n_s = 1'b1;
            skid_cap_s = 1'b1;
          end
        end else begin
          issue_s = 1'b0;
        end
      end
      ST_IDLE, ST_DONE: issue_s = acc_s;
      default:          issue_s = 1'b0;
    endcase
  end

  // Next state; DONE is deferred while a request is outstanding.
  always_comb begin
    sdram_s  = issue_s & (r1_s | r2_s);
    pend_n_s = pend_r | fall_s;
    if (sdram_s) begin
      state_n_s = ST_WAIT;
    end else if ((state_r == ST_WAIT) && !exit_s) begin
      state_n_s = ST_WAIT;
    end else if (pend_n_s) begin
      state_n_s = ST_DONE;
    end else begin
      state_n_s = ST_IDLE;
    end
  end

  // State, handshake bookkeeping and status registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      dl_q_r      <= 1'b0;
      tgt2_r      <= 1'b0;
      pol1_r      <= 1'b0;
      pol2_r      <= 1'b0;
      cnt_r       <= '0;
      skid_v_r    <= 1'b0;
      skid_addr_r <= 25'd0;
      skid_data_r <= 8'd0;
      pend_r      <= 1'b0;
      err_r       <= 1'b0;
      done_r      <= 1'b0;
      wait_r      <= 1'b0;
    end else begin
      state_r <= state_n_s;
      dl_q_r  <= ioctl_download;
      if (sdram_s) begin
        tgt2_r <= r2_s;
        cnt_r  <= '0;
      end else if (state_r == ST_WAIT) begin
        cnt_r <= cnt_r + CNT_ONE;
      end
      // On timeout, realign so the current ack level counts as matching req.
      if (tmo_err_s) begin
        if (tgt2_r) begin
          pol2_r <= port2_ack ^ req2_r;
        end else begin
          pol1_r <= port1_ack ^ req1_r;
        end
      end
      skid_v_r <= skid_v_n_s;
      if (skid_cap_s) begin
        skid_addr_r <= ioctl_addr;
        skid_data_r <= ioctl_dout;
      end
      pend_r <= (state_n_s == ST_DONE) ? 1'b0 : pend_n_s;
      if (tmo_err_s || lost_s) begin
        err_r <= 1'b1;
      end else if (rise_s) begin
        err_r <= 1'b0;
      end
      done_r <= (state_n_s == ST_DONE);
      wait_r <= (state_n_s == ST_WAIT) | skid_v_n_s;
    end
  end

  // Request/payload registers for the three destinations.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      req1_r   <= 1'b0;
      a1_r     <= 23'd0;
      ds1_r    <= 2'b00;
      d1_r     <= 16'd0;
      req2_r   <= 1'b0;
      a2_r     <= 18'd0;
      ds2_r    <= 2'b00;
      d2_r     <= 16'd0;
      dlwr_r   <= 1'b0;
      dladdr_r <= 15'd0;
      dldata_r <= 8'd0;
    end else begin
      dlwr_r <= issue_s & bg_s;
      if (issue_s && r1_s) begin
        req1_r <= ~req1_r;
        a1_r   <= sel_addr_s[23:1];
        ds1_r  <= {sel_addr_s[0], ~sel_addr_s[0]};
        d1_r   <= {sel_data_s, sel_data_s};
      end
      if (issue_s && r2_s) begin
        req2_r <= ~req2_r;
        a2_r   <= {s_off_s[18:17], s_off_s[14:0], s_off_s[16]};
        ds2_r  <= {s_off_s[15], ~s_off_s[15]};
        d2_r   <= {sel_data_s, sel_data_s};
      end
      if (issue_s && bg_s) begin
        dladdr_r <= b_off_s;
        dldata_r <= sel_data_s;
      end
    end
  end

  assign ioctl_wait = wait_r;
  assign port1_req  = req1_r;
  assign port1_a    = a1_r;
  assign port1_ds   = ds1_r;
  assign port1_d    = d1_r;
  assign port2_req  = req2_r;
  assign port2_a    = a2_r;
  assign port2_ds   = ds2_r;
  assign port2_d    = d2_r;
  assign dl_wr      = dlwr_r;
  assign dl_addr    = dladdr_r;
  assign dl_data    = dldata_r;
  assign load_done  = done_r;
  assign load_err   = err_r;

endmodule

// File: tb/tb_rom_loader.sv
// Scoreboard bench for rom_loader: stimulus pushes expected port transactions,
// a negedge monitor pops and compares on every req toggle or dl_wr pulse.
module tb_rom_loader;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download, ioctl_wr;
  logic [7:0]  ioctl_index, ioctl_dout;
  logic [24:0] ioctl_addr;
  logic        ioctl_wait;
  logic        port1_req, port1_ack;
  logic [22:0] port1_a;
  logic [1:0]  port1_ds;
  logic [15:0] port1_d;
  logic        port2_req, port2_ack;
  logic [17:0] port2_a;
  logic [1:0]  port2_ds;
  logic [15:0] port2_d;
  logic        rom_we, dl_wr, load_done, load_err;
  logic [14:0] dl_addr;
  logic [7:0]  dl_data;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          kind;  // 1 = port1, 2 = port2, 3 = background BRAM
    logic [31:0] a;
    logic [1:0]  ds;
    logic [15:0] d;
  } exp_t;
  exp_t sb_q[$];

  logic p1_prev = 1'b0;
  logic p2_prev = 1'b0;
  logic m_req1  = 1'b0;  // bench model of the request toggles
  logic m_req2  = 1'b0;

  rom_loader #(.ACK_TIMEOUT(15)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait),
    .port1_req(port1_req), .port1_ack(port1_ack), .port1_a(port1_a),
    .port1_ds(port1_ds), .port1_d(port1_d),
    .port2_req(port2_req), .port2_ack(port2_ack), .port2_a(port2_a),
    .port2_ds(port2_ds), .port2_d(port2_d),
    .rom_we(rom_we), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
    .load_done(load_done), .load_err(load_err)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [31:0] a, input logic [1:0] ds,
                      input logic [15:0] d);
    exp_t e;
    e.kind = kind; e.a = a; e.ds = ds; e.d = d;
    sb_q.push_back(e);
    if (kind == 1) m_req1 = ~m_req1;
    if (kind == 2) m_req2 = ~m_req2;
  endtask

  task automatic sb_pop(input int kind, input logic [31:0] a, input logic [1:0] ds,
                        input logic [15:0] d);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("unexpected_txn_kind", kind, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk("txn_kind", kind, e.kind);
      chk("txn_addr", a, e.a);
      chk("txn_ds", {30'd0, ds}, {30'd0, e.ds});
      chk("txn_data", {16'd0, d}, {16'd0, e.d});
    end
  endtask

  // Monitor: any req toggle or dl_wr pulse is a transaction to score.
  always @(negedge clk_sys) begin
    if (!reset_n) begin
      p1_prev = port1_req;
      p2_prev = port2_req;
    end else begin
      if (port1_req !== p1_prev) begin
        sb_pop(1, {9'd0, port1_a}, port1_ds, port1_d);
        p1_prev = port1_req;
      end
      if (port2_req !== p2_prev) begin
        sb_pop(2, {14'd0, port2_a}, port2_ds, port2_d);
        p2_prev = port2_req;
      end
      if (dl_wr === 1'b1) sb_pop(3, {17'd0, dl_addr}, 2'b00, {8'd0, dl_data});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic strobe(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
    tick(1);
    ioctl_wr = 1'b0;
  endtask

  // Port 2 write with a short ack delay, then check back-pressure release.
  task automatic p2_xfer(input logic [24:0] a, input logic [7:0] d,
                         input logic [31:0] ea, input logic [1:0] eds);
    push(2, ea, eds, {d, d});
    strobe(a, d);
    chk("p2_wait_hi", {31'd0, ioctl_wait}, 32'd1);
    chk("p2_req", {31'd0, port2_req}, {31'd0, m_req2});
    tick(2);
    port2_ack = ~port2_ack;
    tick(1);
    chk("p2_wait_lo", {31'd0, ioctl_wait}, 32'd0);
  endtask

  task automatic chk_all_zero();
    chk("rst_p1_req", {31'd0, port1_req}, 32'd0);
    chk("rst_p1_a", {9'd0, port1_a}, 32'd0);
    chk("rst_p1_ds_d", {14'd0, port1_ds, port1_d}, 32'd0);
    chk("rst_p2_req", {31'd0, port2_req}, 32'd0);
    chk("rst_p2_a", {14'd0, port2_a}, 32'd0);
    chk("rst_p2_ds_d", {14'd0, port2_ds, port2_d}, 32'd0);
    chk("rst_dl", {8'd0, dl_wr, dl_addr, dl_data}, 32'd0);
    chk("rst_wait", {31'd0, ioctl_wait}, 32'd0);
    chk("rst_done_err", {30'd0, load_done, load_err}, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_index = 8'd0;
    ioctl_addr = 25'd0; ioctl_dout = 8'd0; port1_ack = 1'b0; port2_ack = 1'b0;
    tick(3);
    chk_all_zero();
    reset_n = 1'b1;
    tick(1);
    ioctl_download = 1'b1;
    ioctl_index = 8'd1;
    #1 chk("rom_we_idx1", {31'd0, rom_we}, 32'd0);
    strobe(25'h0000010, 8'h99);  // wrong index: must be ignored
    chk("idx1_no_wait", {31'd0, ioctl_wait}, 32'd0);
    ioctl_index = 8'd0;
    #1 chk("rom_we_idx0", {31'd0, rom_we}, 32'd1);
    tick(2);

    // Port 1 basic write, ack after 5 cycles
    push(1, 32'h1, 2'b10, 16'hA5A5);
    strobe(25'h0000003, 8'hA5);
    chk("p1_wait_hi", {31'd0, ioctl_wait}, 32'd1);
    chk("p1_req_toggle", {31'd0, port1_req}, 32'd1);
    tick(4);
    port1_ack = ~port1_ack;
    chk("p1_wait_held", {31'd0, ioctl_wait}, 32'd1);
    tick(1);
    chk("p1_wait_lo", {31'd0, ioctl_wait}, 32'd0);
    // Port 1 upper boundary
    push(1, 32'h8FFF, 2'b10, 16'h4242);
    strobe(25'h0011FFF, 8'h42);
    tick(1);
    port1_ack = ~port1_ack;
    tick(1);
    chk("p1b_wait_lo", {31'd0, ioctl_wait}, 32'd0);

    // Sprite mapping and port 2 boundaries
    p2_xfer(25'h002A001, 8'h5A, 32'h00003, 2'b10);
    p2_xfer(25'h0012000, 8'h01, 32'h00000, 2'b01);
    p2_xfer(25'h0031FFF, 8'hFE, 32'h0FFFF, 2'b10);

    // Background BRAM writes and the dropped region
    push(3, 32'h0010, 2'b00, 16'h003C);
    strobe(25'h0032010, 8'h3C);
    chk("bg_dl_wr_hi", {31'd0, dl_wr}, 32'd1);
    chk("bg_no_wait", {31'd0, ioctl_wait}, 32'd0);
    tick(1);
    chk("bg_dl_wr_lo", {31'd0, dl_wr}, 32'd0);
    push(3, 32'h7FFF, 2'b00, 16'h0081);
    strobe(25'h0039FFF, 8'h81);
    tick(1);
    strobe(25'h003A000, 8'h77);  // dropped
    chk("drop_no_wait", {31'd0, ioctl_wait}, 32'd0);
    tick(2);

    // Back-pressure: A issues, B skids, C is lost
    push(1, 32'h80, 2'b01, 16'h1111);
    strobe(25'h0000100, 8'h11);
    tick(1);
    push(1, 32'h81, 2'b01, 16'h2222);
    strobe(25'h0000102, 8'h22);
    chk("bp_err_lo", {31'd0, load_err}, 32'd0);
    chk("bp_wait_hi", {31'd0, ioctl_wait}, 32'd1);
    strobe(25'h0000104, 8'h33);
    chk("bp_err_lost", {31'd0, load_err}, 32'd1);
    port1_ack = ~port1_ack;  // ack A
    tick(1);
    chk("bp_second_issue", {31'd0, port1_req}, {31'd0, m_req1});
    chk("bp_wait_still", {31'd0, ioctl_wait}, 32'd1);
    tick(2);
    port1_ack = ~port1_ack;  // ack B
    tick(1);
    chk("bp_wait_lo", {31'd0, ioctl_wait}, 32'd0);
    // Idle completion, then rising edge clears the error
    ioctl_download = 1'b0;
    tick(1);
    chk("idle_done_hi", {31'd0, load_done}, 32'd1);
    tick(1);
    chk("idle_done_lo", {31'd0, load_done}, 32'd0);
    ioctl_download = 1'b1;
    tick(1);
    chk("err_cleared", {31'd0, load_err}, 32'd0);

    // Timeout: never ack
    push(1, 32'h100, 2'b01, 16'h3333);
    strobe(25'h0000200, 8'h33);
    tick(13);
    chk("tmo_err_early", {31'd0, load_err}, 32'd0);
    chk("tmo_wait_early", {31'd0, ioctl_wait}, 32'd1);
    tick(2);
    chk("tmo_err_set", {31'd0, load_err}, 32'd1);
    chk("tmo_wait_lo", {31'd0, ioctl_wait}, 32'd0);
    push(1, 32'h101, 2'b10, 16'h4444);
    strobe(25'h0000203, 8'h44);
    chk("tmo_next_req", {31'd0, port1_req}, {31'd0, m_req1});
    chk("tmo_next_wait", {31'd0, ioctl_wait}, 32'd1);
    tick(2);
    port1_ack = ~port1_ack;
    tick(1);
    chk("tmo_next_wait_lo", {31'd0, ioctl_wait}, 32'd0);

    // Completion deferred while in WAIT
    push(2, 32'h4, 2'b01, 16'h5555);
    strobe(25'h0012002, 8'h55);
    ioctl_download = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("done_deferred", {31'd0, load_done}, 32'd0);
    end
    port2_ack = ~port2_ack;
    tick(1);
    chk("done_after_ack", {31'd0, load_done}, 32'd1);
    chk("done_wait_lo", {31'd0, ioctl_wait}, 32'd0);
    tick(1);
    chk("done_pulse_end", {31'd0, load_done}, 32'd0);
    ioctl_download = 1'b1;
    tick(1);
    chk("err_cleared2", {31'd0, load_err}, 32'd0);

    // Reset mid-WAIT
    push(1, 32'h8, 2'b01, 16'h7777);
    strobe(25'h0000010, 8'h77);
    tick(1);
    reset_n = 1'b0;
    port1_ack = 1'b0; port2_ack = 1'b0;
    m_req1 = 1'b0; m_req2 = 1'b0;
    #1 chk_all_zero();
    tick(2);
    reset_n = 1'b1;
    tick(1);
    push(1, 32'h2, 2'b10, 16'h6666);
    strobe(25'h0000005, 8'h66);
    chk("post_rst_req", {31'd0, port1_req}, 32'd1);
    tick(1);
    port1_ack = ~port1_ack;
    tick(1);
    chk("post_rst_wait_lo", {31'd0, ioctl_wait}, 32'd0);
    tick(3);
    chk("sb_empty", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
